sort4_stream: RTL and testbench
===============================

# sort4_stream

Four-entry stable sorter on 3-bit values. Accepts four values serially through a valid/ready input port, then emits them in ascending order through a valid/ready output port, each tagged with its original arrival index. It is the sequential consumer of a four-way minimum-position comparator: on each output beat it removes the current minimum from the candidate set and re-evaluates the remaining entries.

## Interface
- WIDTH, 3, bit width of each data value; the entry count is fixed at 4.
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents in_data.
- in_data  in  WIDTH  value to load.
- in_ready  out  1  block can accept a value.
- out_valid  out  1  out_data/out_pos hold the next sorted element.
- out_ready  in  1  downstream accepts the current element.
- out_data  out  WIDTH  sorted value.
- out_pos  out  2  original arrival index (0–3) of out_data.
- out_last  out  1  high with the 4th (final) output element.

## Operation
- States: LOAD, EMIT.
- LOAD: in_ready=1, out_valid=0. On in_valid&in_ready, store in_data into slot[cnt] and increment cnt (2-bit). Slot index equals arrival order (0–3). When the 4th accept occurs (cnt==3), go to EMIT. Clear cnt to 0 and clear the 4-bit taken mask.
- EMIT: in_ready=0; in_valid is ignored. out_valid=1. out_data/out_pos are the minimum among slots whose taken bit is 0.
  - Comparison is unsigned.
  - Ties resolve to the lowest slot index, so the sort is stable.
- Output transfer occurs on out_valid&out_ready. On transfer, set taken[out_pos] and increment cnt. out_last = (cnt==3) while in EMIT.
- After the transfer with out_last=1, go to LOAD. cnt returns to 0.
- Taken slots are excluded from the comparison entirely, not replaced by a sentinel value. This keeps the value 7 (all-ones) sortable.
- Data registers keep stale contents between batches. They do not need to be cleared.

## Timing
- Reset values: state=LOAD, cnt=0, taken=0, in_ready=1, out_valid=0, out_data=0, out_pos=0, out_last=0.
- Load phase: one value per cycle while in_valid is held.
- First out_valid is asserted in the cycle after the 4th input accept (1-cycle latency).
- Emit phase: one element per cycle while out_ready is held. The full batch takes 4 emit cycles.
- in_ready is asserted again in the cycle after the final output transfer. There is no overlap of load and emit.
- Back-pressure: while out_valid=1 and out_ready=0, out_data, out_pos and out_last stay stable and cnt/taken do not change.
- out_data and out_pos are combinational from the slot registers and the taken mask. They do not depend combinationally on in_valid or out_ready.
- rst asserted in any state, including mid-load or mid-emit, takes effect at the next edge. The partial batch is discarded and all outputs return to their reset values.
- Simultaneous in_valid and out_ready are legal. Only the handshake belonging to the current state has any effect.

## Structure
- Shared package: state encoding constants (ST_LOAD, ST_EMIT), ENTRIES=4, POS_W=2.
- Sub-module min_index4 (combinational):
  - Inputs: four WIDTH-bit values and a 4-bit enable mask.
  - Outputs: min value and a 2-bit index.
  - Ties go to the lowest index; disabled entries are never selected.
- The top level holds the FSM, the cnt register, the taken register, the slot registers and the handshake logic.

## Test plan
- Load 5,2,7,2 with out_ready=1 → outputs (2,pos1), (2,pos3), (5,pos0), (7,pos2). out_last is high only on the 4th output. in_ready=1 on the following cycle.
- Load 3,3,3,3 → pos 0,1,2,3 in order, all with out_data=3 (stability check).
- Load 7,0,7,6 and toggle out_ready 1,0,0,1,1,0,1 → sequence (0,1), (6,3), (7,0), (7,2). Outputs are held unchanged during every out_ready=0 cycle.
- Load 4,1 then hold in_valid=0 for 3 cycles, then load 6,0 → in_ready stays 1 and no output appears until after the 4th accept. Result: (0,3), (1,1), (4,0), (6,2).
- Assert rst for 1 cycle after the 2nd output of a batch → next cycle shows out_valid=0 and in_ready=1. A fresh batch 1,2,3,4 then sorts to positions 0,1,2,3.
- Drive in_valid=1 with in_data=0 throughout an emit phase of batch 6,5,4,3 → in_ready stays 0 and the output order is unaffected: (3,3), (4,2), (5,1), (6,0).

Source files
------------

// File: rtl/sort4_stream_pkg.sv
// Shared constants and state encoding for the four-entry stream sorter.
package sort4_stream_pkg;

    localparam int ENTRIES = 4;
    localparam int POS_W   = 2;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/min_index4.sv
// Combinational four-way minimum finder over enabled entries.
// Ties resolve to the lowest index, which keeps the downstream sort stable.
module min_index4
    import sort4_stream_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [ENTRIES-1:0][WIDTH-1:0] vals,
    input  logic [ENTRIES-1:0]            en,
    output logic [WIDTH-1:0]              min_val,
    output logic [POS_W-1:0]              min_idx
);

    logic             lo_sel;
    logic             hi_sel;
    logic             lo_en;
    logic             hi_en;
    logic             take_lo;
    logic [WIDTH-1:0] lo_val;
    logic [WIDTH-1:0] hi_val;
    logic [POS_W-1:0] lo_idx;
    logic [POS_W-1:0] hi_idx;

    // Pairwise reduction; "<=" favours the lower index on equal values.
    always_comb begin
        lo_sel  = en[0] && (!en[1] || (vals[0] <= vals[1]));
        lo_val  = lo_sel ? vals[0] : vals[1];
        lo_idx  = lo_sel ? 2'd0 : 2'd1;
        lo_en   = en[0] || en[1];

        hi_sel  = en[2] && (!en[3] || (vals[2] <= vals[3]));
        hi_val  = hi_sel ? vals[2] : vals[3];
        hi_idx  = hi_sel ? 2'd2 : 2'd3;
        hi_en   = en[2] || en[3];

        take_lo = lo_en && (!hi_en || (lo_val <= hi_val));
        min_val = take_lo ? lo_val : hi_val;
        min_idx = take_lo ? lo_idx : hi_idx;
    end

endmodule

// File: rtl/sort4_stream.sv
// Four-entry stable sorter: loads four values serially, then emits them
// in ascending order tagged with their arrival index.
module sort4_stream
    import sort4_stream_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [POS_W-1:0] out_pos,
    output logic             out_last
);

    state_t                        state;
    state_t                        state_next;
    logic [POS_W-1:0]              cnt;
    logic [ENTRIES-1:0]            taken;
    logic [ENTRIES-1:0][WIDTH-1:0] slots;
    logic [WIDTH-1:0]              min_val;
    logic [POS_W-1:0]              min_idx;
    logic                          load_fire;
    logic                          emit_fire;

    min_index4 #(.WIDTH(WIDTH)) u_min (
        .vals    (slots),
        .en      (~taken),
        .min_val (min_val),
        .min_idx (min_idx)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_pos    = '0;
        out_last   = 1'b0;
        load_fire  = 1'b0;
        emit_fire  = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready  = 1'b1;
                load_fire = in_valid;
                if (load_fire && (cnt == 2'd3)) state_next = ST_EMIT;
            end
            ST_EMIT: begin
                // Outputs are forced to zero outside EMIT so stale slots never leak.
                out_valid = 1'b1;
                out_data  = min_val;
                out_pos   = min_idx;
                out_last  = (cnt == 2'd3);
                emit_fire = out_ready;
                if (emit_fire && out_last) state_next = ST_LOAD;
            end
        endcase
    end

    // cnt wraps 3->0 on its own at the end of both phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
            cnt   <= '0;
            taken <= '0;
        end else begin
            state <= state_next;
            if (load_fire) begin
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3) taken <= '0;
            end
            if (emit_fire) begin
                cnt            <= cnt + 2'd1;
                taken[min_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire) slots[cnt] <= in_data;
    end

endmodule

// File: tb/tb_sort4_stream.sv
// Directed self-checking bench for sort4_stream with hand-computed expectations.
module tb_sort4_stream;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_data;
    logic [1:0] out_pos;
    logic       out_last;

    int checks   = 0;
    int failures = 0;

    sort4_stream #(.WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pos   (out_pos),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [2:0] id, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
    endtask

    task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [2:0] ed,
                               input logic [1:0] ep, input logic el, input logic er);
        check1({tag, "_out_valid"}, {7'd0, out_valid}, {7'd0, ev});
        check1({tag, "_out_data"},  {5'd0, out_data},  {5'd0, ed});
        check1({tag, "_out_pos"},   {6'd0, out_pos},   {6'd0, ep});
        check1({tag, "_out_last"},  {7'd0, out_last},  {7'd0, el});
        check1({tag, "_in_ready"},  {7'd0, in_ready},  {7'd0, er});
    endtask

    task automatic checkIdle(input string tag);
        checkOutput(tag, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
    endtask

    // out_ready is held high during load to show it has no effect there.
    task automatic loadStep(input string tag, input logic [2:0] d);
        applyStimulus(1'b1, d, 1'b1);
        checkIdle(tag);
        tick();
    endtask

    task automatic loadBatch(input string tag, input logic [2:0] d0, input logic [2:0] d1,
                             input logic [2:0] d2, input logic [2:0] d3);
        loadStep({tag, "_ld0"}, d0);
        loadStep({tag, "_ld1"}, d1);
        loadStep({tag, "_ld2"}, d2);
        loadStep({tag, "_ld3"}, d3);
    endtask

    task automatic emitStep(input string tag, input logic iv, input logic ordy,
                            input logic [2:0] ed, input logic [1:0] ep, input logic el);
        applyStimulus(iv, 3'd0, ordy);
        checkOutput(tag, 1'b1, ed, ep, el, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0);
        tick();
        tick();
        checkIdle("reset");
        rst = 1'b0;

        $display("[TB] batch 5,2,7,2");
        loadBatch("b1", 3'd5, 3'd2, 3'd7, 3'd2);
        emitStep("b1_e0", 1'b0, 1'b1, 3'd2, 2'd1, 1'b0);
        emitStep("b1_e1", 1'b0, 1'b1, 3'd2, 2'd3, 1'b0);
        emitStep("b1_e2", 1'b0, 1'b1, 3'd5, 2'd0, 1'b0);
        emitStep("b1_e3", 1'b0, 1'b1, 3'd7, 2'd2, 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkIdle("b1_done");

        $display("[TB] batch 3,3,3,3");
        loadBatch("b2", 3'd3, 3'd3, 3'd3, 3'd3);
        emitStep("b2_e0", 1'b0, 1'b1, 3'd3, 2'd0, 1'b0);
        emitStep("b2_e1", 1'b0, 1'b1, 3'd3, 2'd1, 1'b0);
        emitStep("b2_e2", 1'b0, 1'b1, 3'd3, 2'd2, 1'b0);
        emitStep("b2_e3", 1'b0, 1'b1, 3'd3, 2'd3, 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkIdle("b2_done");

        $display("[TB] batch 7,0,7,6 with back-pressure");
        loadBatch("b3", 3'd7, 3'd0, 3'd7, 3'd6);
        emitStep("b3_c0", 1'b0, 1'b1, 3'd0, 2'd1, 1'b0);
        emitStep("b3_c1", 1'b0, 1'b0, 3'd6, 2'd3, 1'b0);
        emitStep("b3_c2", 1'b0, 1'b0, 3'd6, 2'd3, 1'b0);
        emitStep("b3_c3", 1'b0, 1'b1, 3'd6, 2'd3, 1'b0);
        emitStep("b3_c4", 1'b0, 1'b1, 3'd7, 2'd0, 1'b0);
        emitStep("b3_c5", 1'b0, 1'b0, 3'd7, 2'd2, 1'b1);
        emitStep("b3_c6", 1'b0, 1'b1, 3'd7, 2'd2, 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkIdle("b3_done");

        $display("[TB] batch 4,1 gap 6,0");
        loadStep("b4_ld0", 3'd4);
        loadStep("b4_ld1", 3'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 3'd5, 1'b1);
            checkIdle($sformatf("b4_gap%0d", i));
            tick();
        end
        loadStep("b4_ld2", 3'd6);
        loadStep("b4_ld3", 3'd0);
        emitStep("b4_e0", 1'b0, 1'b1, 3'd0, 2'd3, 1'b0);
        emitStep("b4_e1", 1'b0, 1'b1, 3'd1, 2'd1, 1'b0);
        emitStep("b4_e2", 1'b0, 1'b1, 3'd4, 2'd0, 1'b0);
        emitStep("b4_e3", 1'b0, 1'b1, 3'd6, 2'd2, 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkIdle("b4_done");

        $display("[TB] reset mid-emit");
        loadBatch("b5", 3'd5, 3'd2, 3'd7, 3'd2);
        emitStep("b5_e0", 1'b0, 1'b1, 3'd2, 2'd1, 1'b0);
        emitStep("b5_e1", 1'b0, 1'b1, 3'd2, 2'd3, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0);
        tick();
        rst = 1'b0;
        checkIdle("b5_after_rst");
        loadBatch("b6", 3'd1, 3'd2, 3'd3, 3'd4);
        emitStep("b6_e0", 1'b0, 1'b1, 3'd1, 2'd0, 1'b0);
        emitStep("b6_e1", 1'b0, 1'b1, 3'd2, 2'd1, 1'b0);
        emitStep("b6_e2", 1'b0, 1'b1, 3'd3, 2'd2, 1'b0);
        emitStep("b6_e3", 1'b0, 1'b1, 3'd4, 2'd3, 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkIdle("b6_done");

        $display("[TB] batch 6,5,4,3 with in_valid held during emit");
        loadBatch("b7", 3'd6, 3'd5, 3'd4, 3'd3);
        emitStep("b7_e0", 1'b1, 1'b1, 3'd3, 2'd3, 1'b0);
        emitStep("b7_e1", 1'b1, 1'b1, 3'd4, 2'd2, 1'b0);
        emitStep("b7_e2", 1'b1, 1'b1, 3'd5, 2'd1, 1'b0);
        emitStep("b7_e3", 1'b1, 1'b1, 3'd6, 2'd0, 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkIdle("b7_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
